// File: rtl/li_pkg.sv
// Shared helpers for the li_* latency-insensitive blocks: clog2 and token widths.
package li_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int p = 1; p < v; p = p * 2) r++;
    return r;
  endfunction

  // Data width of a port; WIDTH=0 (token-only) still carries a 1-bit bus.
  function automatic int data_w(input int width);
    return (width > 0) ? width : 1;
  endfunction

  // Stored token = {data, en}.
  function automatic int tok_w(input int width);
    return data_w(width) + 1;
  endfunction

endpackage

// File: rtl/li_token_ring.sv
// Circular token buffer of N entries with push/pop/clear; pointers wrap at N-1 so N need
// not be a power of two.
module li_token_ring
  import li_pkg::*;
#(
  parameter int TW = 2,
  parameter int N  = 1,
  parameter int CW = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [TW-1:0] din_i,
  output logic [TW-1:0] dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] cnt_o
);

  localparam int PW = (N > 1) ? clog2(N) : 1;

  logic [TW-1:0] mem_q [N];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(N - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = nxt(wr_q);
      if (pop_i)  rd_d = nxt(rd_q);
      if (push_i && !pop_i)      cnt_d = cnt_q + CW'(1);
      else if (pop_i && !push_i) cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage carries no reset; occupancy is tracked by cnt_q alone.
  always_ff @(posedge clk_i) begin
    if (push_i && !clr_i) mem_q[wr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_q];
  assign full_o  = (cnt_q == CW'(N));
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/li_reg_queue.sv
// Latency-insensitive register with a DEPTH-slot token buffer (head + DEPTH-1 ring).
// Optional FLUSH port enabled by defining LI_REG_FLUSH_EN.
module li_reg_queue
  import li_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2,
  parameter int INIT  = 0
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [data_w(WIDTH)-1:0]  IN_WRITE,
  input  logic                      IN_WRITE_VALID,
  output logic                      IN_WRITE_CONSUMED,
  input  logic                      IN_EN_WRITE,
  input  logic                      IN_EN_WRITE_VALID,
  output logic                      IN_EN_WRITE_CONSUMED,
  output logic [data_w(WIDTH)-1:0]  OUT_READ,
  output logic                      OUT_READ_VALID,
  input  logic                      OUT_READ_CONSUMED,
  output logic [clog2(DEPTH+1)-1:0] OCCUPANCY
`ifdef LI_REG_FLUSH_EN
  ,
  input  logic                      FLUSH
`endif
);

  localparam int W  = data_w(WIDTH);
  localparam int TW = tok_w(WIDTH);
  localparam int C  = clog2(DEPTH + 1);
  localparam logic [W-1:0] INIT_V = W'(INIT);

  logic          flush;
  logic          inp, cons, enq, deq, load, push, pop;
  logic          pend_full, pend_empty;
  logic [W-1:0]  in_data;
  logic [TW-1:0] in_tok, ring_tok, apply_tok;
  logic [C-1:0]  cnt;
  logic          hd_valid_q, hd_valid_d;
  logic [W-1:0]  hd_data_q, hd_data_d;

`ifdef LI_REG_FLUSH_EN
  assign flush = FLUSH;
`else
  assign flush = 1'b0;
`endif

  // Both halves of a token must be present together; CONSUMED never looks at the consumer.
  assign inp  = ((WIDTH == 0) ? 1'b1 : IN_WRITE_VALID) & IN_EN_WRITE_VALID;
  assign cons = flush ? !inp : (inp ? !pend_full : 1'b1);
  assign IN_WRITE_CONSUMED    = cons;
  assign IN_EN_WRITE_CONSUMED = cons;

  assign enq  = inp & !pend_full & !flush;
  assign deq  = hd_valid_q & ((WIDTH == 0) ? 1'b1 : OUT_READ_CONSUMED);
  assign load = deq | !hd_valid_q;
  assign pop  = load & !pend_empty & !flush;
  assign push = enq & !(load & pend_empty);

  assign in_data   = (WIDTH == 0) ? '0 : IN_WRITE;
  assign in_tok    = {in_data, IN_EN_WRITE};
  assign apply_tok = pop ? ring_tok : in_tok;

  li_token_ring #(
    .TW (TW),
    .N  (DEPTH - 1),
    .CW (C)
  ) u_ring (
    .clk_i   (CLK),
    .rst_i   (RST),
    .clr_i   (flush),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (in_tok),
    .dout_o  (ring_tok),
    .full_o  (pend_full),
    .empty_o (pend_empty),
    .cnt_o   (cnt)
  );

  // An en=0 token still occupies the head but re-presents the previous value.
  always_comb begin
    hd_valid_d = hd_valid_q;
    hd_data_d  = hd_data_q;
    if (pop || (enq && load)) begin
      hd_valid_d = 1'b1;
      if (apply_tok[0]) hd_data_d = apply_tok[TW-1:1];
    end else if (deq) begin
      hd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hd_valid_q <= 1'b1;
      hd_data_q  <= INIT_V;
    end else begin
      hd_valid_q <= hd_valid_d;
      hd_data_q  <= hd_data_d;
    end
  end

  assign OUT_READ       = hd_data_q;
  assign OUT_READ_VALID = hd_valid_q;
  assign OCCUPANCY      = C'(hd_valid_q) + cnt;

endmodule
